comparador_serie: RTL and testbench

- Parametrised, sequential successor to the 4-bit combinational magnitude comparator.
- Compares two WIDTH-bit operands bit-serially, MSB first, one bit per clock.
- Uses a start/busy/done handshake; produces registered G/L/E flags.
- Supports signed or unsigned mode and optional early termination on the first differing bit.
- Sits between operand-producing logic (switch/UART front ends) and LED/result consumers on the EDU-CIAA FPGA.

---
 rtl/comparador_serie_pkg.sv | 16 +
 rtl/comparador_1b.sv | 24 ++
 rtl/comparador_serie.sv | 131 +++++++++++++
 tb/tb_comparador_serie.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/comparador_serie_pkg.sv
// Shared definitions for the bit-serial magnitude comparator.
package comparador_serie_pkg;

    // Controller states; encoding is kept fixed so it can be probed on hardware.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Bit-counter width: enough to hold WIDTH-1, never narrower than one bit.
    function automatic int cnt_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/comparador_1b.sv
// Single-bit comparison cell fed with the current MSBs of both shift registers.
// With inv=1 (sign bit of a two's-complement compare) the sense is swapped:
// a set sign bit means the operand is the smaller one.
module comparador_1b (
    input  logic a_bit,
    input  logic b_bit,
    input  logic inv,
    output logic gt,
    output logic lt
);

    logic w_a_hi;
    logic w_b_hi;

    assign w_a_hi = a_bit & ~b_bit;
    assign w_b_hi = ~a_bit & b_bit;

    // Pick the ordering based on whether this is the sign bit
    always_comb begin
        gt = inv ? w_b_hi : w_a_hi;
        lt = inv ? w_a_hi : w_b_hi;
    end

endmodule

// File: rtl/comparador_serie.sv
// Bit-serial magnitude comparator, MSB first, one bit per clock.
// start/busy/done handshake with registered G/L/E flags; all-zero flags mean
// "no valid result". Optional two's-complement mode and early termination.
module comparador_serie
    import comparador_serie_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int SIGNED     = 0,
    parameter int EARLY_EXIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             G,
    output logic             L,
    output logic             E
);

    localparam int CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_t           r_state;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [CW-1:0]    r_cnt;
    logic             r_first;   // next processed bit is the MSB (sign bit)
    logic             r_dec;     // a differing bit has already been seen
    logic             r_dec_g;   // direction of that first difference

    logic w_gt;
    logic w_lt;
    logic w_inv;
    logic w_new_dec;
    logic w_last;
    logic w_accept;

    assign w_inv     = (SIGNED != 0) && r_first;
    assign w_new_dec = !r_dec && (w_gt || w_lt);
    assign w_last    = (r_cnt == '0);
    // A new operation can be accepted from IDLE or straight out of DONE
    assign w_accept  = start && (r_state == S_IDLE || r_state == S_DONE);

    comparador_1b u_bit (
        .a_bit (r_sa[WIDTH-1]),
        .b_bit (r_sb[WIDTH-1]),
        .inv   (w_inv),
        .gt    (w_gt),
        .lt    (w_lt)
    );

    // Controller, operand shift registers, bit counter and result flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_sa    <= '0;
            r_sb    <= '0;
            r_cnt   <= '0;
            r_first <= 1'b0;
            r_dec   <= 1'b0;
            r_dec_g <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            G       <= 1'b0;
            L       <= 1'b0;
            E       <= 1'b0;
        end else if (w_accept) begin
            r_state <= S_SHIFT;
            r_sa    <= a;
            r_sb    <= b;
            r_cnt   <= CNT_LAST;
            r_first <= 1'b1;
            r_dec   <= 1'b0;
            r_dec_g <= 1'b0;
            busy    <= 1'b1;
            done    <= 1'b0;
            G       <= 1'b0;
            L       <= 1'b0;
            E       <= 1'b0;
        end else begin
            case (r_state)
                S_SHIFT: begin
                    if ((EARLY_EXIT != 0) && w_new_dec) begin
                        // First difference settles it; stop right here
                        G       <= w_gt;
                        L       <= w_lt;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end else if (w_last) begin
                        // Earlier decision wins over whatever the LSB says
                        if (r_dec) begin
                            G <= r_dec_g;
                            L <= !r_dec_g;
                        end else if (w_new_dec) begin
                            G <= w_gt;
                            L <= w_lt;
                        end else begin
                            E <= 1'b1;
                        end
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        if (w_new_dec) begin
                            r_dec   <= 1'b1;
                            r_dec_g <= w_gt;
                        end
                        r_sa    <= r_sa << 1;
                        r_sb    <= r_sb << 1;
                        r_cnt   <= r_cnt - CNT_ONE;
                        r_first <= 1'b0;
                    end
                end
                S_DONE: begin
                    // done is a single-cycle pulse; flags stay until next accept
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_comparador_serie.sv
// Directed bench for comparador_serie across several parameter sets.
// Instances: 0 = W4 unsigned early, 1 = W4 unsigned full-length,
// 2 = W4 signed early, 3 = W1 signed early, 4 = W8 unsigned early,
// 5 = W8 signed early.
module tb_comparador_serie;

    logic       clk;
    logic       rst;
    logic [5:0] start_v;
    logic [7:0] a8;
    logic [7:0] b8;
    logic [5:0] busy_v;
    logic [5:0] done_v;
    logic [5:0] g_v;
    logic [5:0] l_v;
    logic [5:0] e_v;

    int total;
    int bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    comparador_serie #(.WIDTH(4), .SIGNED(0), .EARLY_EXIT(1)) u0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .a(a8[3:0]), .b(b8[3:0]),
        .busy(busy_v[0]), .done(done_v[0]), .G(g_v[0]), .L(l_v[0]), .E(e_v[0]));
    comparador_serie #(.WIDTH(4), .SIGNED(0), .EARLY_EXIT(0)) u1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .a(a8[3:0]), .b(b8[3:0]),
        .busy(busy_v[1]), .done(done_v[1]), .G(g_v[1]), .L(l_v[1]), .E(e_v[1]));
    comparador_serie #(.WIDTH(4), .SIGNED(1), .EARLY_EXIT(1)) u2 (
        .clk(clk), .rst(rst), .start(start_v[2]), .a(a8[3:0]), .b(b8[3:0]),
        .busy(busy_v[2]), .done(done_v[2]), .G(g_v[2]), .L(l_v[2]), .E(e_v[2]));
    comparador_serie #(.WIDTH(1), .SIGNED(1), .EARLY_EXIT(1)) u3 (
        .clk(clk), .rst(rst), .start(start_v[3]), .a(a8[0:0]), .b(b8[0:0]),
        .busy(busy_v[3]), .done(done_v[3]), .G(g_v[3]), .L(l_v[3]), .E(e_v[3]));
    comparador_serie #(.WIDTH(8), .SIGNED(0), .EARLY_EXIT(1)) u4 (
        .clk(clk), .rst(rst), .start(start_v[4]), .a(a8), .b(b8),
        .busy(busy_v[4]), .done(done_v[4]), .G(g_v[4]), .L(l_v[4]), .E(e_v[4]));
    comparador_serie #(.WIDTH(8), .SIGNED(1), .EARLY_EXIT(1)) u5 (
        .clk(clk), .rst(rst), .start(start_v[5]), .a(a8), .b(b8),
        .busy(busy_v[5]), .done(done_v[5]), .G(g_v[5]), .L(l_v[5]), .E(e_v[5]));

    typedef struct {
        int       dut;
        logic [7:0] a;
        logic [7:0] b;
        logic     g;
        logic     l;
        logic     e;
        int       lat;
    } vec_t;

    localparam int NV = 15;
    vec_t vec [NV];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Pulse start on one instance and check latency, flags and the done pulse
    task automatic run_op(input int d, input logic [7:0] av, input logic [7:0] bv,
                          input logic eg, input logic el, input logic ee,
                          input int elat, input string tag);
        int lat;
        @(negedge clk);
        a8 = av;
        b8 = bv;
        start_v[d] = 1'b1;
        @(posedge clk);
        #1;
        start_v[d] = 1'b0;
        a8 = ~av;   // operands must already be latched
        b8 = ~bv;
        chk({tag, " busy"}, int'(busy_v[d]), 1);
        lat = 0;
        while (!done_v[d] && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, " latency"}, lat, elat);
        chk({tag, " G"}, int'(g_v[d]), int'(eg));
        chk({tag, " L"}, int'(l_v[d]), int'(el));
        chk({tag, " E"}, int'(e_v[d]), int'(ee));
        @(posedge clk);
        #1;
        chk({tag, " done pulse ends"}, int'(done_v[d]), 0);
        chk({tag, " flags hold"}, int'({g_v[d], l_v[d], e_v[d]}), int'({eg, el, ee}));
    endtask

    initial begin
        int dcount;
        int lat;
        total   = 0;
        bad     = 0;
        rst     = 1'b1;
        start_v = '0;
        a8      = '0;
        b8      = '0;

        vec[0]  = '{0, 8'h04, 8'h04, 1'b0, 1'b0, 1'b1, 4};
        vec[1]  = '{0, 8'h04, 8'h01, 1'b1, 1'b0, 1'b0, 2};
        vec[2]  = '{1, 8'h04, 8'h01, 1'b1, 1'b0, 1'b0, 4};
        vec[3]  = '{0, 8'h04, 8'h0E, 1'b0, 1'b1, 1'b0, 1};
        vec[4]  = '{2, 8'h04, 8'h0E, 1'b1, 1'b0, 1'b0, 1};
        vec[5]  = '{3, 8'h01, 8'h00, 1'b0, 1'b1, 1'b0, 1};
        vec[6]  = '{3, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1};
        vec[7]  = '{3, 8'h00, 8'h01, 1'b1, 1'b0, 1'b0, 1};
        vec[8]  = '{4, 8'h80, 8'h7F, 1'b1, 1'b0, 1'b0, 1};
        vec[9]  = '{5, 8'h80, 8'h7F, 1'b0, 1'b1, 1'b0, 1};
        vec[10] = '{1, 8'h04, 8'h04, 1'b0, 1'b0, 1'b1, 4};
        vec[11] = '{2, 8'h07, 8'h07, 1'b0, 1'b0, 1'b1, 4};
        vec[12] = '{4, 8'h12, 8'h13, 1'b0, 1'b1, 1'b0, 8};
        vec[13] = '{2, 8'h0F, 8'h0E, 1'b1, 1'b0, 1'b0, 4};
        vec[14] = '{1, 8'h03, 8'h09, 1'b0, 1'b1, 1'b0, 4};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", int'(busy_v), 0);
        chk("reset done", int'(done_v), 0);
        chk("reset flags", int'({g_v, l_v, e_v}), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NV; i++)
            run_op(vec[i].dut, vec[i].a, vec[i].b, vec[i].g, vec[i].l, vec[i].e,
                   vec[i].lat, $sformatf("vec%0d", i));

        // start held through a whole full-length operation, then into DONE
        @(negedge clk);
        a8 = 8'h03;
        b8 = 8'h09;
        start_v[1] = 1'b1;
        @(posedge clk);
        #1;
        a8 = 8'h0F;
        b8 = 8'h00;
        dcount = 0;
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk);
            #1;
            if (done_v[1]) dcount++;
        end
        chk("held start no early done", dcount, 0);
        @(posedge clk);
        #1;
        chk("held start done", int'(done_v[1]), 1);
        chk("held start L", int'({g_v[1], l_v[1], e_v[1]}), 3'b010);
        @(posedge clk);
        #1;
        chk("back-to-back busy", int'(busy_v[1]), 1);
        chk("back-to-back done low", int'(done_v[1]), 0);
        chk("back-to-back flags cleared", int'({g_v[1], l_v[1], e_v[1]}), 0);
        start_v[1] = 1'b0;
        lat = 0;
        while (!done_v[1] && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("back-to-back latency", lat, 4);
        chk("back-to-back G", int'({g_v[1], l_v[1], e_v[1]}), 3'b100);
        repeat (2) @(posedge clk);

        // Asynchronous reset in the middle of SHIFT
        @(negedge clk);
        a8 = 8'h04;
        b8 = 8'h04;
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("async rst busy", int'(busy_v[0]), 0);
        chk("async rst done", int'(done_v[0]), 0);
        chk("async rst flags", int'({g_v[0], l_v[0], e_v[0]}), 0);
        dcount = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            if (done_v[0]) dcount++;
        end
        chk("no done after rst", dcount, 0);
        @(negedge clk);
        rst = 1'b0;
        run_op(0, 8'h0F, 8'h00, 1'b1, 1'b0, 1'b0, 1, "post-rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
